jt93cx6: RTL and testbench

Parametrised Microwire serial EEPROM emulator covering the 93C46/56/66/86 family in x8 or x16 organisation. It sits between a CPU core's EEPROM I/O bits (sclk/sdi/scs/sdo) and an internal word array. A host-side port loads and dumps contents for NVRAM save and restore. It supersedes the fixed 93C46 x16 block by adding a configurable geometry, write/erase-all, a busy/ready status and a dirty flag.

---
 rtl/jt93cx6_if.sv | 30 +++
 rtl/jt93cx6.sv | 163 ++++++++++++++++
 tb/tb_jt93cx6.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt93cx6_if.sv
// jt93cx6_if: bus bundle for the jt93cx6 Microwire EEPROM emulator.
//   Serial side : sclk, sdi, scs (to EEPROM), sdo (from EEPROM)
//   Host side   : host_addr, host_we, host_din (to EEPROM), host_dout (from EEPROM)
//   Status      : dirty (from EEPROM), dirty_clr (to EEPROM)
// slave modport is the EEPROM, master modport is the CPU/host side.
interface jt93cx6_if #(
   parameter int AW = 6,
   parameter int DW = 16
) ();
   logic          sclk;
   logic          sdi;
   logic          scs;
   logic          sdo;
   logic [AW-1:0] host_addr;
   logic          host_we;
   logic [DW-1:0] host_din;
   logic [DW-1:0] host_dout;
   logic          dirty;
   logic          dirty_clr;

   modport slave (
      input  sclk, sdi, scs, host_addr, host_we, host_din, dirty_clr,
      output sdo, host_dout, dirty
   );

   modport master (
      output sclk, sdi, scs, host_addr, host_we, host_din, dirty_clr,
      input  sdo, host_dout, dirty
   );
endinterface

// File: rtl/jt93cx6.sv
// jt93cx6: Microwire serial EEPROM emulator, 93C46/56/66/86 in x8 or x16.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    jt93cx6_if.slave: serial sclk/sdi/scs -> sdo, host load/dump port
//          (host_addr/host_we/host_din -> host_dout, 1-cycle latency),
//          dirty flag with dirty_clr.
// Optional feature: define JT93CX6_SEQREAD_EN to let READ keep streaming
// consecutive words (address auto-increments with wrap) after the first word.
module jt93cx6 #(
   parameter int AW          = 6,
   parameter int DW          = 16,
   parameter int PROG_CYCLES = 64
) (
   input  logic     clk,
   input  logic     rst_n,
   jt93cx6_if.slave bus
);
   localparam int DEPTH = 2**AW;
   localparam int BUSY  = (PROG_CYCLES > DEPTH) ? PROG_CYCLES : DEPTH;
   localparam int BW    = $clog2(BUSY + 1);
   localparam int CW    = $clog2(((AW > DW) ? AW : DW) + 1);

   typedef enum logic [2:0] {IDLE, OP, ADDR, WDATA, RDATA, WAIT, PROG, READY} st_t;

   st_t           st;
   logic          sclk_r, sclk_l, sdi_r, scs_r;
   logic [1:0]    op;
   logic [AW-1:0] addr;
   logic [DW-1:0] sr;          // write data / read shift register
   logic [CW-1:0] cnt;
   logic [BW-1:0] busy;
   logic          wen;         // write-enable latch (EWEN/EWDS)
   logic          wc;          // a write-class command is waiting for scs fall
   logic          all;         // WRAL/ERAL: sweep every address
   logic          pend;        // serial commit still owed to the array
   logic          sdo_r, dirty_r;
   logic [DW-1:0] hdout_r;

   // Array is never reset; power-up content is all ones like a blank part.
   logic [DW-1:0] mem [DEPTH] = '{default: {DW{1'b1}}};

   logic          rise, ser_we, last_wr, done;
   logic [AW-1:0] a_next;

   assign rise    = sclk_r & ~sclk_l;
   assign a_next  = {addr[AW-2:0], sdi_r};
   // Host port owns the single write port; a colliding serial commit waits.
   assign ser_we  = (st == PROG) && pend && !bus.host_we;
   assign last_wr = ser_we && (!all || (&addr));
   assign done    = (busy == BW'(BUSY - 1)) && !(pend && !last_wr);

   assign bus.sdo       = sdo_r;
   assign bus.dirty     = dirty_r;
   assign bus.host_dout = hdout_r;

   always_ff @(posedge clk) begin
      if (bus.host_we)  mem[bus.host_addr] <= bus.host_din;
      else if (ser_we)  mem[addr]          <= sr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hdout_r <= '0;
      else        hdout_r <= mem[bus.host_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_r <= 1'b0; sclk_l <= 1'b0; sdi_r <= 1'b0; scs_r <= 1'b0;
         st     <= IDLE;
         op     <= '0;   addr  <= '0;   sr   <= '0;   cnt  <= '0;  busy <= '0;
         wen    <= 1'b0; wc    <= 1'b0; all  <= 1'b0; pend <= 1'b0;
         sdo_r  <= 1'b1; dirty_r <= 1'b0;
      end else begin
         sclk_r <= bus.sclk;
         sclk_l <= sclk_r;
         sdi_r  <= bus.sdi;
         scs_r  <= bus.scs;
         if (bus.dirty_clr) dirty_r <= 1'b0;   // a set later in this block wins
         case (st)
            IDLE: begin
               sdo_r <= 1'b1; wc <= 1'b0; all <= 1'b0; cnt <= '0;
               if (scs_r && rise && sdi_r) st <= OP;
            end
            OP: if (!scs_r) st <= IDLE;
               else if (rise) begin
                  op  <= {op[0], sdi_r};
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(1)) begin cnt <= '0; st <= ADDR; end
               end
            ADDR: if (!scs_r) st <= IDLE;
               else if (rise) begin
                  addr <= a_next;
                  cnt  <= cnt + CW'(1);
                  if (cnt == CW'(AW - 1)) begin
                     cnt <= '0;
                     case (op)
                        2'b10: begin st <= RDATA; sdo_r <= 1'b0; sr <= mem[a_next]; end
                        2'b01: begin st <= WDATA; wc <= 1'b1; end
                        2'b11: begin st <= WAIT;  wc <= 1'b1; sr <= '1; end
                        default: case (a_next[AW-1:AW-2])
                           2'b11:   begin st <= WAIT; wen <= 1'b1; end
                           2'b00:   begin st <= WAIT; wen <= 1'b0; end
                           2'b01:   begin st <= WDATA; wc <= 1'b1; all <= 1'b1; addr <= '0; end
                           default: begin st <= WAIT; wc <= 1'b1; all <= 1'b1; addr <= '0; sr <= '1; end
                        endcase
                     endcase
                  end
               end
            WDATA: if (!scs_r) st <= IDLE;
               else if (rise) begin
                  sr  <= {sr[DW-2:0], sdi_r};
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(DW - 1)) st <= WAIT;
               end
            RDATA: if (!scs_r) st <= IDLE;
               else if (rise) begin
`ifdef JT93CX6_SEQREAD_EN
                  sdo_r <= sr[DW-1];
                  sr    <= {sr[DW-2:0], 1'b0};
                  cnt   <= cnt + CW'(1);
                  // next word follows the last bit directly, no dummy bit
                  if (cnt == CW'(DW - 1)) begin
                     cnt  <= '0;
                     addr <= addr + AW'(1);
                     sr   <= mem[addr + AW'(1)];
                  end
`else
                  if (cnt == CW'(DW)) begin
                     st <= WAIT; sdo_r <= 1'b0;
                  end else begin
                     sdo_r <= sr[DW-1];
                     sr    <= {sr[DW-2:0], 1'b0};
                     cnt   <= cnt + CW'(1);
                  end
`endif
               end
            WAIT: if (!scs_r) begin
                  if (wc && wen) begin
                     st <= PROG; busy <= '0; pend <= 1'b1; dirty_r <= 1'b1; sdo_r <= 1'b0;
                  end else st <= IDLE;
               end
            PROG: begin
               sdo_r <= 1'b0;
               if (busy != BW'(BUSY - 1)) busy <= busy + BW'(1);
               if (ser_we) begin
                  if (all && !(&addr)) addr <= addr + AW'(1);
                  else                 pend <= 1'b0;
               end
               if (done) begin st <= READY; sdo_r <= 1'b1; end
            end
            READY: begin
               sdo_r <= 1'b1;
               if (!scs_r) st <= IDLE;
               else if (rise && sdi_r) begin   // this rise is the next start bit
                  st <= OP; cnt <= '0; wc <= 1'b0; all <= 1'b0;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jt93cx6.sv
module tb_jt93cx6;
   localparam int AW = 6, DW = 16, DEPTH = 64;
   localparam int K_SDO = 0, K_HD = 1, K_DIRTY = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   jt93cx6_if #(.AW(AW), .DW(DW)) bus ();
   jt93cx6 #(.AW(AW), .DW(DW), .PROG_CYCLES(64)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   typedef struct { int kind; string name; logic [DW-1:0] val; } exp_t;
   exp_t          exp_q[$];
   logic          smp = 1'b0;
   int            checks = 0, errors = 0;
   logic [DW-1:0] model [DEPTH];
   bit            m_wen = 0, m_dirty = 0;

   // monitor: whenever the stimulus marks an output as presented, pop and compare
   always @(negedge clk) if (smp) begin
      exp_t e;
      logic [DW-1:0] act;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty");
      end else begin
         e = exp_q.pop_front();
         case (e.kind)
            K_SDO:   act = {{(DW-1){1'b0}}, bus.sdo};
            K_HD:    act = bus.host_dout;
            default: act = {{(DW-1){1'b0}}, bus.dirty};
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic expect_out(input int k, input string nm, input logic [DW-1:0] v);
      exp_t e;
      e.kind = k; e.name = nm; e.val = v;
      exp_q.push_back(e);
      smp = 1'b1;
      @(posedge clk); #1;
      smp = 1'b0;
   endtask

   task automatic hwrite(input int a, input logic [DW-1:0] d);
      bus.host_addr = AW'(a); bus.host_din = d; bus.host_we = 1'b1;
      @(posedge clk); #1;
      bus.host_we = 1'b0;
      model[a] = d;
   endtask

   task automatic hread(input int a, input string nm);
      bus.host_addr = AW'(a);
      @(posedge clk); #1;
      expect_out(K_HD, nm, model[a]);
   endtask

   task automatic sbit(input logic b);
      bus.sdi = b; bus.sclk = 1'b0;
      repeat (3) @(posedge clk); #1;
      bus.sclk = 1'b1;
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic send(input int n, input logic [31:0] v);
      for (int i = n - 1; i >= 0; i--) sbit(v[i]);
   endtask

   function automatic logic [31:0] cmd9(input logic [1:0] op, input logic [5:0] a);
      return {23'd0, 1'b1, op, a};
   endfunction

   task automatic cs_start();
      bus.scs = 1'b1; bus.sclk = 1'b0; bus.sdi = 1'b0;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic cs_low();
      bus.sclk = 1'b0; bus.scs = 1'b0;
      repeat (2) @(posedge clk); #1;
   endtask

   // drop scs; if a commit is expected, check busy status then ready status
   task automatic finish_cmd(input bit commit, input int hold);
      cs_low();
      repeat (hold) @(posedge clk);
      if (hold > 0) #1;
      bus.host_we = 1'b0;
      if (commit) begin
         expect_out(K_SDO, "busy_start", 0);
         repeat (57 - hold) @(posedge clk); #1;
         expect_out(K_SDO, "busy_end", 0);
         bus.scs = 1'b1;
         for (int i = 0; i < 200; i++) begin
            if (bus.sdo) break;
            @(posedge clk); #1;
         end
         expect_out(K_SDO, "ready", 1);
         cs_low();
      end else expect_out(K_SDO, "no_prog", 1);
   endtask

   task automatic ser_read(input int a, input int n);
      cs_start();
      send(9, cmd9(2'b10, 6'(a)));
      expect_out(K_SDO, "rd_dummy", 0);
      for (int i = 0; i < n; i++) begin
         logic [DW-1:0] w;
         int wi, bi;
         wi = i / DW; bi = DW - 1 - (i % DW);
`ifdef JT93CX6_SEQREAD_EN
         w = model[(a + wi) % DEPTH];
`else
         w = (wi == 0) ? model[a] : '0;
`endif
         sbit(1'b0);
         expect_out(K_SDO, "rd_bit", {{(DW-1){1'b0}}, w[bi]});
      end
      cs_low();
   endtask

   task automatic ser_write(input int a, input logic [DW-1:0] d, input int hold);
      cs_start();
      send(9, cmd9(2'b01, 6'(a)));
      send(16, {16'd0, d});
      if (hold > 0) begin end
      finish_cmd(m_wen, hold);
      if (m_wen) begin model[a] = d; m_dirty = 1; end
   endtask

   task automatic ser_erase(input int a);
      cs_start();
      send(9, cmd9(2'b11, 6'(a)));
      finish_cmd(m_wen, 0);
      if (m_wen) begin model[a] = '1; m_dirty = 1; end
   endtask

   task automatic ser_ext(input logic [1:0] code);
      cs_start();
      send(9, cmd9(2'b00, {code, 4'b0}));
      cs_low();
      if (code == 2'b11) m_wen = 1;
      if (code == 2'b00) m_wen = 0;
   endtask

   task automatic ser_all(input bit wr, input logic [DW-1:0] d);
      cs_start();
      send(9, cmd9(2'b00, {(wr ? 2'b01 : 2'b10), 4'b0}));
      if (wr) send(16, {16'd0, d});
      finish_cmd(m_wen, 0);
      if (m_wen) begin
         for (int i = 0; i < DEPTH; i++) model[i] = wr ? d : '1;
         m_dirty = 1;
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < DEPTH; i++) begin
         logic [DW-1:0] d;
         d = DW'($urandom);
         if (d == 16'hA5A5) d = 16'h0;
         hwrite(i, d);
      end
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.sclk = 0; bus.sdi = 0; bus.scs = 0;
      bus.host_addr = '0; bus.host_we = 0; bus.host_din = '0; bus.dirty_clr = 0;
      repeat (3) @(posedge clk); #1;
      expect_out(K_SDO, "rst_sdo", 1);
      expect_out(K_HD, "rst_hdout", 0);
      expect_out(K_DIRTY, "rst_dirty", 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      load_random();
      hwrite(5, 16'h1234);
      ser_read(5, 16);

      // write with latch clear: nothing happens
      ser_write(5, 16'hBEEF, 0);
      hread(5, "wr_locked");
      expect_out(K_DIRTY, "dirty_locked", {15'b0, m_dirty});

      ser_ext(2'b11);
      ser_write(5, 16'hBEEF, 0);
      hread(5, "wr_commit");
      expect_out(K_DIRTY, "dirty_set", {15'b0, m_dirty});
      bus.dirty_clr = 1'b1; @(posedge clk); #1; bus.dirty_clr = 1'b0;
      m_dirty = 0;
      expect_out(K_DIRTY, "dirty_clr", {15'b0, m_dirty});

      for (int it = 0; it < 10; it++) begin
         int a;
         a = $urandom_range(0, DEPTH - 1);
         case ($urandom_range(0, 3))
            0: ser_read(a, 16);
            1: begin ser_write(a, DW'($urandom), 0); hread(a, "rnd_wr"); end
            2: begin ser_erase(a); hread(a, "rnd_erase"); end
            default: ser_ext($urandom_range(0, 1) ? 2'b11 : 2'b00);
         endcase
      end
      expect_out(K_DIRTY, "dirty_rnd", {15'b0, m_dirty});

      // host write overlapping the serial commit: both must land
      ser_ext(2'b11);
      bus.host_addr = 6'd9; bus.host_din = 16'h5A5A;
      cs_start();
      send(9, cmd9(2'b01, 6'd3));
      send(16, 32'h0000C0DE);
      bus.host_we = 1'b1;
      finish_cmd(1, 4);
      model[3] = 16'hC0DE; model[9] = 16'h5A5A; m_dirty = 1;
      hread(3, "coll_serial");
      hread(9, "coll_host");

      ser_all(0, '0);
      for (int i = 0; i < DEPTH; i++) hread(i, "eral");
      expect_out(K_DIRTY, "dirty_eral", 1);

      // abort in the middle of write data
      hwrite(7, 16'h7E57);
      cs_start();
      send(9, cmd9(2'b01, 6'd7));
      send(8, 32'h000000BE);
      cs_low();
      expect_out(K_SDO, "abort_idle", 1);
      ser_read(7, 16);

      // reset while WRAL is sweeping the array
      load_random();
      cs_start();
      send(9, cmd9(2'b00, 6'b010000));
      send(16, 32'h0000A5A5);
      cs_low();
      repeat (20) @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      expect_out(K_SDO, "wral_rst_sdo", 1);
      expect_out(K_DIRTY, "wral_rst_dirty", 0);
      rst_n = 1'b1; m_wen = 0; m_dirty = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) model[i] = 16'hA5A5;
      for (int i = 0; i < 10; i++) hread(i, "wral_done");
      for (int i = 30; i < DEPTH; i++) hread(i, "wral_untouched");
      for (int i = 10; i < 30; i++) hwrite(i, DW'($urandom));

      // latch must be disabled after reset
      ser_write(12, 16'hDEAD, 0);
      hread(12, "post_rst_locked");
      expect_out(K_DIRTY, "post_rst_dirty", 0);

      ser_read(63, 32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
